reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the staged, synchronous reset outputs for one clock domain from a board-level asynchronous reset, a PLL lock indication and a software reset request. It sits upstream of the per-domain reset synchronizers and drives subsystem resets. Resets assert immediately. Release happens only after lock is qualified and a minimum hold time has elapsed, and then goes stage by stage, stage 0 first, with a fixed gap between stages. A status output reports when every stage has been released.

## Interface
- NUM_STAGE, 3: number of reset outputs, released in index order; must be ≥1.
- HOLD_CYCLE, 16: minimum cycles all stages stay asserted before stage 0 releases; must be ≥1.
- STAGE_GAP, 8: cycles between consecutive stage releases; must be ≥1.
- LOCK_FILTER, 4: consecutive synchronized-lock-high cycles required to qualify lock; must be ≥1.
- OUT_RST_ACTIVE, {NUM_STAGE{1'b1}}: per-stage polarity mask. Bit i = 1 makes o_srst[i] active-high; bit i = 0 makes it active-low.
- i_clk  in  1  sole clock.
- i_arst  in  1  asynchronous, active-high reset.
- i_pll_locked  in  1  asynchronous PLL lock; synchronized internally by 2 flops.
- i_sw_rst_req  in  1  single-cycle software reset request, synchronous to i_clk.
- o_srst  out  NUM_STAGE  staged resets, registered; polarity per OUT_RST_ACTIVE.
- o_rst_done  out  1  high when all stages are released.

## Operation
- While i_arst is high, or asynchronously on its rising edge:
  - all o_srst bits are asserted (o_srst = OUT_RST_ACTIVE);
  - o_rst_done = 0;
  - state = WAIT_LOCK;
  - counters and both lock-sync flops are 0.
- States and transitions:
  - WAIT_LOCK: all stages asserted. Each edge, if lock_sync = 1: when cnt == LOCK_FILTER-1, go to HOLD with cnt <= 0; otherwise cnt++. If lock_sync = 0, cnt <= 0. i_sw_rst_req is ignored.
  - HOLD: all stages asserted. Each edge: when cnt == HOLD_CYCLE-1, go to RELEASE, deassert stage 0, stage index <= 1, cnt <= 0; otherwise cnt++.
  - RELEASE: each edge, when cnt == STAGE_GAP-1, deassert stage[idx], idx++, cnt <= 0; otherwise cnt++. Releasing stage NUM_STAGE-1 moves the state to RUN and sets o_rst_done = 1 on the same edge.
  - If NUM_STAGE = 1, the HOLD exit goes directly to RUN, with done set on that edge.
  - RUN: all stages released, o_rst_done = 1.
- Lock loss: lock_sync = 0 in HOLD, RELEASE or RUN. On that edge all stages reassert, o_rst_done = 0, state = WAIT_LOCK, cnt = 0.
- Software request: i_sw_rst_req = 1 in HOLD, RELEASE or RUN. On that edge all stages reassert, o_rst_done = 0, state = HOLD, cnt = 0. In HOLD this restarts the hold count.
- Priority: i_arst > lock loss > i_sw_rst_req > counting.
- A stage, once released, stays released until the next reassertion event. Released stages never reassert individually; all stages always reassert together.
- Counter width is $clog2 of the largest of LOCK_FILTER, HOLD_CYCLE and STAGE_GAP, minimum 1 bit. Stage index width is $clog2(NUM_STAGE+1).

## Timing
- Edge n = the n-th rising i_clk edge after i_arst deasserts.
- With i_pll_locked held high, lock_sync is 1 from edge 2.
- HOLD is entered at edge LOCK_FILTER+2.
- Stage k releases at edge LOCK_FILTER+2+HOLD_CYCLE+k·STAGE_GAP. o_rst_done rises with the last stage.
- Defaults: stage 0 releases at edge 22, stage 1 at 30, stage 2 at 38, and o_rst_done at 38.
- Lock-loss latency: i_pll_locked falling before edge m gives reassertion at edge m+2.
- Software-request latency: a request sampled at edge m gives reassertion at edge m. Stage 0 then releases at edge m+HOLD_CYCLE.
- A lock glitch shorter than LOCK_FILTER cycles in WAIT_LOCK only restarts the filter count.

## Test plan
- Lock held high, default parameters: o_srst = 3'b111 until edge 22; 3'b110 at edge 22; 3'b100 at edge 30; 3'b000 and o_rst_done = 1 at edge 38.
- OUT_RST_ACTIVE = 3'b010: o_srst = 3'b010 during reset. Releases give 3'b011, then 3'b001, then 3'b101, at the same edges as the first scenario.
- Lock pulses low for 2 cycles during WAIT_LOCK at edges 4–5: the filter restarts, and HOLD is entered 4 cycles after lock_sync returns high. Lock dropped in RUN: all stages reassert 2 edges later, done falls, and the full sequence repeats.
- i_sw_rst_req pulse at edge 33 (stages 0 and 1 released): all stages reassert at edge 33; stage 0 releases at edge 49, stage 2 and done at edge 65.
- i_arst asserted mid-RELEASE between clock edges: o_srst asserts and o_rst_done falls without any clock edge. The sequence restarts from edge 1 after deassertion.
- NUM_STAGE = 1, HOLD_CYCLE = 1, LOCK_FILTER = 1: o_srst releases and o_rst_done rises together at edge 4.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged synchronous reset release for one clock domain.
// Qualifies PLL lock, holds, then releases stages in index order.
module reset_sequencer #(
  parameter int NUM_STAGE   = 3,
  parameter int HOLD_CYCLE  = 16,
  parameter int STAGE_GAP   = 8,
  parameter int LOCK_FILTER = 4,
  parameter logic [NUM_STAGE-1:0] OUT_RST_ACTIVE =
    {NUM_STAGE{1'b1}}
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic                 i_pll_locked,
  input  logic                 i_sw_rst_req,
  output logic [NUM_STAGE-1:0] o_srst,
  output logic                 o_rst_done
);

  localparam int MX_A =
    (LOCK_FILTER > HOLD_CYCLE) ? LOCK_FILTER : HOLD_CYCLE;
  localparam int MX =
    (MX_A > STAGE_GAP) ? MX_A : STAGE_GAP;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam int IW = $clog2(NUM_STAGE + 1);

  localparam logic [CW-1:0] LF_LAST =
    CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYCLE - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] STAGE_LAST =
    IW'(NUM_STAGE - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          sync0;
  logic          sync1;
  logic          lock_sync;
  logic          active;

  assign lock_sync = sync1;
  assign active    = (state != WAIT_LOCK);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      state      <= WAIT_LOCK;
      cnt        <= '0;
      idx        <= '0;
      o_srst     <= OUT_RST_ACTIVE;
      o_rst_done <= 1'b0;
    end else begin
      sync0 <= i_pll_locked;
      sync1 <= sync0;
      if (active && !lock_sync) begin
        state      <= WAIT_LOCK;
        cnt        <= '0;
        idx        <= '0;
        o_srst     <= OUT_RST_ACTIVE;
        o_rst_done <= 1'b0;
      end else if (active && i_sw_rst_req) begin
        state      <= HOLD;
        cnt        <= '0;
        idx        <= '0;
        o_srst     <= OUT_RST_ACTIVE;
        o_rst_done <= 1'b0;
      end else begin
        unique case (state)
          WAIT_LOCK: begin
            if (!lock_sync) begin
              cnt <= '0;
            end else if (cnt == LF_LAST) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt       <= '0;
              o_srst[0] <= ~OUT_RST_ACTIVE[0];
              if (NUM_STAGE == 1) begin
                state      <= RUN;
                o_rst_done <= 1'b1;
              end else begin
                state <= RELEASE;
                idx   <= IW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RELEASE: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              idx <= idx + IW'(1);
              // one-hot match keeps the index width free of select warnings
              for (int i = 0; i < NUM_STAGE; i++) begin
                if (idx == IW'(i)) begin
                  o_srst[i] <= ~OUT_RST_ACTIVE[i];
                end
              end
              if (idx == STAGE_LAST) begin
                state      <= RUN;
                o_rst_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RUN: begin
            o_rst_done <= 1'b1;
          end
          default: begin
            state <= WAIT_LOCK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer.
// Three instances: defaults, mixed polarity, single stage.
module tb_reset_sequencer;

  logic       clk;
  logic       arst;
  logic       lock;
  logic       sw;
  logic [2:0] srst_def;
  logic       done_def;
  logic [2:0] srst_pol;
  logic       done_pol;
  logic [0:0] srst_one;
  logic       done_one;

  int e;
  int n_chk;
  int n_fail;

  reset_sequencer u_def (
    .i_clk       (clk),
    .i_arst      (arst),
    .i_pll_locked(lock),
    .i_sw_rst_req(sw),
    .o_srst      (srst_def),
    .o_rst_done  (done_def)
  );

  reset_sequencer #(
    .OUT_RST_ACTIVE(3'b010)
  ) u_pol (
    .i_clk       (clk),
    .i_arst      (arst),
    .i_pll_locked(lock),
    .i_sw_rst_req(sw),
    .o_srst      (srst_pol),
    .o_rst_done  (done_pol)
  );

  reset_sequencer #(
    .NUM_STAGE     (1),
    .HOLD_CYCLE    (1),
    .LOCK_FILTER   (1),
    .OUT_RST_ACTIVE(1'b1)
  ) u_one (
    .i_clk       (clk),
    .i_arst      (arst),
    .i_pll_locked(lock),
    .i_sw_rst_req(sw),
    .o_srst      (srst_one),
    .o_rst_done  (done_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h",
               tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    lock = 1'b1;
    sw   = 1'b0;
    repeat (3) tick();
    arst = 1'b0;
    e    = 0;
  endtask

  function automatic logic [2:0] staged(int t, int r0);
    if (t < r0)      return 3'b111;
    if (t < r0 + 8)  return 3'b110;
    if (t < r0 + 16) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] pol_exp(int t);
    if (t < 22) return 3'b010;
    if (t < 30) return 3'b011;
    if (t < 38) return 3'b001;
    return 3'b101;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    e      = 0;
    arst   = 1'b1;
    lock   = 1'b1;
    sw     = 1'b0;
    #1;
    check("rst_def", 32'(srst_def), 32'h7);
    check("rst_done", 32'(done_def), 32'h0);
    check("rst_pol", 32'(srst_pol), 32'h2);
    check("rst_one", 32'(srst_one), 32'h1);
    check("rst_one_done", 32'(done_one), 32'h0);

    // basic release on all three instances
    do_reset();
    for (int t = 1; t <= 40; t++) begin
      tick();
      check("s1_srst", 32'(srst_def), 32'(staged(e, 22)));
      check("s1_done", 32'(done_def), 32'(e >= 38));
      check("s1_pol", 32'(srst_pol), 32'(pol_exp(e)));
      check("s1_pol_done", 32'(done_pol), 32'(e >= 38));
      check("s1_one", 32'(srst_one), 32'(e < 4));
      check("s1_one_done", 32'(done_one), 32'(e >= 4));
    end

    // lock glitch in WAIT_LOCK, then lock loss in RUN
    do_reset();
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (e == 3) lock = 1'b0;
      if (e == 5) lock = 1'b1;
      check("s2_srst", 32'(srst_def), 32'(staged(e, 27)));
      check("s2_done", 32'(done_def), 32'(e >= 43));
      if (e == 45) lock = 1'b0;
    end
    for (int t = 46; t <= 90; t++) begin
      tick();
      if (e == 48) lock = 1'b1;
      if (e < 48) begin
        check("s3_srst", 32'(srst_def), 32'h0);
        check("s3_done", 32'(done_def), 32'h1);
      end else begin
        check("s3_srst", 32'(srst_def), 32'(staged(e, 70)));
        check("s3_done", 32'(done_def), 32'(e >= 86));
      end
    end

    // software request after stage 1 release
    do_reset();
    for (int t = 1; t <= 68; t++) begin
      tick();
      sw = (e == 32);
      if (e < 33) begin
        check("s4_srst", 32'(srst_def), 32'(staged(e, 22)));
      end else begin
        check("s4_srst", 32'(srst_def), 32'(staged(e, 49)));
      end
      check("s4_done", 32'(done_def), 32'(e >= 65));
    end

    // async reset mid-release, then in RUN
    do_reset();
    for (int t = 1; t <= 25; t++) begin
      tick();
    end
    check("s5_pre", 32'(srst_def), 32'h6);
    #3;
    arst = 1'b1;
    #1;
    check("s5_async_srst", 32'(srst_def), 32'h7);
    check("s5_async_done", 32'(done_def), 32'h0);
    do_reset();
    for (int t = 1; t <= 40; t++) begin
      tick();
      check("s6_srst", 32'(srst_def), 32'(staged(e, 22)));
      check("s6_done", 32'(done_def), 32'(e >= 38));
    end
    #3;
    arst = 1'b1;
    #1;
    check("s6_async_srst", 32'(srst_def), 32'h7);
    check("s6_async_done", 32'(done_def), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
